// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver FSM state encoding and the baud divisors
// (clock cycles per bit at 12 MHz), the same values the transmitter uses.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        LOAD = 2'd2,
        DAV  = 2'd3
    } rx_state_e;

    localparam int B115200 = 104;
    localparam int B57600  = 208;
    localparam int B38400  = 313;
    localparam int B19200  = 625;
    localparam int B9600   = 1250;
    localparam int B4800   = 2500;
    localparam int B2400   = 5000;
    localparam int B1200   = 10000;
    localparam int B600    = 20000;
    localparam int B300    = 40000;

endpackage

// File: rtl/baudgen_rx.sv
// Mid-bit tick generator for the UART receiver. The counter sits at 0 while
// disabled, so the first tick after enabling lands half a bit in (the middle
// of the start bit) and later ticks follow one full bit apart.
module baudgen_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD = B300
) (
    input  logic clk,
    input  logic rstn,
    input  logic clk_ena,
    output logic clk_out
);

    localparam int CW = $clog2(BAUD);
    localparam logic [CW-1:0] LAST = CW'(BAUD - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD / 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: hold at zero when disabled, otherwise count and wrap per bit.
    always_comb begin
        cnt_d = '0;
        if (clk_ena) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign clk_out = (cnt_q == HALF);

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronizes rx, samples each bit at mid-bit and presents
// the byte on data with a one-cycle rcv strobe.
// Optional macro UART_RX_FRAMING_CHECK_EN: frames whose stop bit reads 0 are
// dropped and reported with a one-cycle ferr pulse instead of rcv.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD = B300
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr
);

    logic       rx_meta_q;
    logic       rx_s_q;
    rx_state_e  state_q;
    rx_state_e  state_d;
    logic [3:0] bitc_q;
    logic [9:0] shifter_q;
    logic [7:0] data_q;
    logic       tick;
    logic       baud_ena;
    logic       load;
    logic       unused_start;
`ifdef UART_RX_FRAMING_CHECK_EN
    logic       ferr_q;
    logic       ferr_d;
`endif

    assign baud_ena = (state_q == RECV);

    baudgen_rx #(.BAUD(BAUD)) u_baudgen (
        .clk     (clk),
        .rstn    (rstn),
        .clk_ena (baud_ena),
        .clk_out (tick)
    );

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Bit counter, shift register and output byte register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bitc_q    <= 4'd0;
            shifter_q <= 10'h3FF;
            data_q    <= 8'h00;
        end else begin
            if (state_q == IDLE) bitc_q <= 4'd0;
            else if (tick)       bitc_q <= bitc_q + 4'd1;
            if (tick)            shifter_q <= {rx_s_q, shifter_q[9:1]};
            if (load)            data_q <= shifter_q[8:1];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; the first tick rejects a start bit that has gone high again.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
`ifdef UART_RX_FRAMING_CHECK_EN
        ferr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: if (!rx_s_q) state_d = RECV;
            RECV: begin
                if (tick && (bitc_q == 4'd0) && rx_s_q) state_d = IDLE;
                else if (bitc_q == 4'd10)                state_d = LOAD;
            end
            LOAD: begin
`ifdef UART_RX_FRAMING_CHECK_EN
                if (!shifter_q[9]) begin
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    load    = 1'b1;
                    state_d = DAV;
                end
`else
                load    = 1'b1;
                state_d = DAV;
`endif
            end
            DAV:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_RX_FRAMING_CHECK_EN
    // Frame error pulse lands in the cycle where rcv would otherwise be high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ferr_q <= 1'b0;
        else       ferr_q <= ferr_d;
    end
    assign ferr = ferr_q;
`else
    assign ferr = 1'b0;
`endif

    // The start bit ends up in shifter_q[0] and carries no information.
    assign unused_start = shifter_q[0];

    assign data = data_q;
    assign rcv  = (state_q == DAV);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 8 clocks per bit: directed frames, glitch, bad stop bit,
// mid-frame reset, then random frames checked against a frame-level model.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int B = 8;
`ifdef UART_RX_FRAMING_CHECK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        bit         is_ferr;
        int         t0;
    } ev_t;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rx   = 1'b1;
    logic [7:0] data;
    logic       rcv;
    logic       ferr;

    int  nchk = 0;
    int  nerr = 0;
    int  cyc  = 0;
    int  rcv_cnt = 0;
    int  ferr_cnt = 0;
    int  exp_rcv = 0;
    int  exp_ferr = 0;
    ev_t expq[$];
    ev_t mon_e;
    bit  prev_rcv  = 1'b0;
    bit  prev_ferr = 1'b0;
    int  lat;

    uart_rx #(.BAUD(B)) dut (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .data (data),
        .rcv  (rcv),
        .ferr (ferr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serial model: one 8N1 frame, LSB first; records what the receiver must report.
    task automatic send_frame(input logic [7:0] d, input bit stop);
        ev_t e;
        e.d       = d;
        e.is_ferr = FCHK && !stop;
        e.t0      = cyc;
        expq.push_back(e);
        if (e.is_ferr) exp_ferr++;
        else           exp_rcv++;
        rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (B) @(negedge clk);
        end
        rx = stop;
        repeat (B) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * B) @(negedge clk);
    endtask

    task automatic drain();
        int k = 0;
        while (expq.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("drain", expq.size(), 0);
        expq.delete();
    endtask

    // Event monitor: every rcv/ferr pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_rcv  = 1'b0;
            prev_ferr = 1'b0;
        end else begin
            if (prev_rcv)  chk("rcv_pulse_len", rcv, 0);
            if (prev_ferr) chk("ferr_pulse_len", ferr, 0);
            if (rcv) rcv_cnt++;
            if (ferr) ferr_cnt++;
            if (rcv || ferr) begin
                if (expq.size() == 0) begin
                    chk("unexpected_event", {rcv, ferr}, 0);
                end else begin
                    mon_e = expq.pop_front();
                    chk("event_ferr", ferr, mon_e.is_ferr);
                    chk("event_rcv", rcv, !mon_e.is_ferr);
                    if (rcv) chk("data", data, mon_e.d);
                    lat = cyc - mon_e.t0;
                    chk("latency", 32'(lat >= (19 * B) / 2 - 2 && lat <= (19 * B) / 2 + 8), 1);
                end
            end
            prev_rcv  = rcv;
            prev_ferr = ferr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        int f0;
        logic [7:0] d;
        logic [7:0] rdat;
        bit stop;

        rstn = 1'b0;
        rx   = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data", data, 8'h00);
        chk("reset_rcv", rcv, 0);
        chk("reset_ferr", ferr, 0);
        chk("reset_state", 32'(dut.state_q), 32'(IDLE));
        rstn = 1'b1;
        idle_bits(2);

        // Single byte 'A'
        r0 = rcv_cnt;
        send_frame(8'h41, 1'b1);
        idle_bits(2);
        drain();
        chk("A_data", data, 8'h41);
        chk("A_rcv_count", rcv_cnt - r0, 1);
        chk("A_ferr_count", ferr_cnt, 0);

        // Back-to-back frames with a single stop bit
        r0 = rcv_cnt;
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        idle_bits(2);
        drain();
        chk("b2b_rcv_count", rcv_cnt - r0, 2);
        chk("b2b_data", data, 8'hAA);

        // Two-cycle glitch on the idle line
        r0 = rcv_cnt;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (B / 2 + 2) @(negedge clk);
        chk("glitch_idle", 32'(dut.state_q), 32'(IDLE));
        idle_bits(2);
        chk("glitch_no_rcv", rcv_cnt - r0, 0);
        chk("glitch_data", data, 8'hAA);

        // 0x3C with a zero stop bit
        r0 = rcv_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        idle_bits(2);
        drain();
        chk("badstop_rcv", rcv_cnt - r0, FCHK ? 0 : 1);
        chk("badstop_ferr", ferr_cnt - f0, FCHK ? 1 : 0);
        chk("badstop_data", data, FCHK ? 8'hAA : 8'h3C);

        // Reset during bit 4 of a frame
        d  = 8'h5A;
        rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (B) @(negedge clk);
        end
        rx = d[4];
        repeat (B / 2) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_data", data, 8'h00);
        chk("midrst_rcv", rcv, 0);
        chk("midrst_ferr", ferr, 0);
        chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        idle_bits(11);
        send_frame(8'h7E, 1'b1);
        idle_bits(2);
        drain();
        chk("post_rst_data", data, 8'h7E);

        // Random frames, random stop bits and gaps
        rdat = 8'h7E;
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            if (stop || !FCHK) rdat = d;
            send_frame(d, stop);
            idle_bits($urandom_range(0, 2) + (stop ? 0 : 1));
        end
        idle_bits(2);
        drain();
        chk("rand_last_data", data, rdat);
        chk("total_rcv", rcv_cnt, exp_rcv);
        chk("total_ferr", ferr_cnt, exp_ferr);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
